// File: rtl/pipe_trace_pkg.sv
// Shared types and default widths for the WISC pipeline instruction-trace producer.
package pipe_trace_pkg;

  localparam int PT_ID_W       = 16;
  localparam int PT_CYC_W      = 32;
  localparam int PT_STALL_W    = 4;
  localparam int PT_FIFO_DEPTH = 8;

  typedef struct packed {
    logic                  valid;
    logic [PT_ID_W-1:0]    id;
    logic [15:0]           pc;
    logic [15:0]           instr;
    logic [PT_CYC_W-1:0]   fetch_cyc;
    logic [PT_STALL_W-1:0] stall_cnt;
  } stage_slot_t;

  typedef struct packed {
    logic [PT_ID_W-1:0]    id;
    logic [15:0]           pc;
    logic [15:0]           instr;
    logic [PT_CYC_W-1:0]   fetch_cyc;
    logic [PT_CYC_W-1:0]   wb_cyc;
    logic [PT_STALL_W-1:0] stall_cnt;
  } trace_rec_t;

endpackage

// File: rtl/pipe_trace_tracker_if.sv
// Fetch/hazard inputs and the retire-record valid/ready port of the trace tracker.
interface pipe_trace_tracker_if
  import pipe_trace_pkg::*;
#(
  parameter int ID_W    = PT_ID_W,
  parameter int CYC_W   = PT_CYC_W,
  parameter int STALL_W = PT_STALL_W
);

  logic               fetch_valid;
  logic [15:0]        pc_in;
  logic [15:0]        instr_in;
  logic               stall;
  logic               flush;
  logic               rec_valid;
  logic               rec_ready;
  logic [ID_W-1:0]    rec_id;
  logic [15:0]        rec_pc;
  logic [15:0]        rec_instr;
  logic [CYC_W-1:0]   rec_fetch_cyc;
  logic [CYC_W-1:0]   rec_wb_cyc;
  logic [STALL_W-1:0] rec_stall_cnt;
  logic [CYC_W-1:0]   cycle;
  logic [7:0]         drop_cnt;
  logic               overflow;

  modport master (
    input  fetch_valid, pc_in, instr_in, stall, flush, rec_ready,
    output rec_valid, rec_id, rec_pc, rec_instr, rec_fetch_cyc, rec_wb_cyc,
           rec_stall_cnt, cycle, drop_cnt, overflow
  );

  modport slave (
    output fetch_valid, pc_in, instr_in, stall, flush, rec_ready,
    input  rec_valid, rec_id, rec_pc, rec_instr, rec_fetch_cyc, rec_wb_cyc,
           rec_stall_cnt, cycle, drop_cnt, overflow
  );

endinterface

// File: rtl/pipe_trace_tracker_fifo.sv
// Retire-record FIFO; extra pointer MSB distinguishes full from empty.
module trace_fifo
  import pipe_trace_pkg::*;
#(
  parameter int DEPTH = PT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  trace_rec_t i_data,
  output trace_rec_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  trace_rec_t  r_mem [DEPTH];
  logic        w_wr_en;
  logic        w_rd_en;

  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  // A pop frees the head slot in the same edge, so a full FIFO still accepts.
  assign w_wr_en = i_push && (!o_full || i_pop);
  assign w_rd_en = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/pipe_trace_tracker.sv
// Shadows the WISC IF/ID..MEM/WB registers, stamps cycles and queues one trace record per retire.
module pipe_trace_tracker
  import pipe_trace_pkg::*;
#(
  parameter int ID_W       = PT_ID_W,
  parameter int CYC_W      = PT_CYC_W,
  parameter int STALL_W    = PT_STALL_W,
  parameter int FIFO_DEPTH = PT_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_trace_tracker_if.master bus
);

  stage_slot_t      r_ifid_p0;
  stage_slot_t      r_idex_p1;
  stage_slot_t      r_exmem_p2;
  stage_slot_t      r_memwb_p3;
  logic [ID_W-1:0]  r_next_id;
  logic [CYC_W-1:0] r_cycle;
  logic [7:0]       r_drop_cnt;
  logic             r_overflow;

  trace_rec_t w_rec;
  trace_rec_t w_head;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;

  function automatic logic [STALL_W-1:0] sat_stall(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

  function automatic logic [7:0] sat_drop(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  // Stage boundary: fetch -> IF/ID -> ID/EX -> EX/MEM -> MEM/WB
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_p0.valid  <= 1'b0;
      r_idex_p1.valid  <= 1'b0;
      r_exmem_p2.valid <= 1'b0;
      r_memwb_p3.valid <= 1'b0;
      r_next_id        <= '0;
      r_cycle          <= '0;
    end else begin
      r_cycle    <= r_cycle + CYC_W'(1);
      r_exmem_p2 <= r_idex_p1;
      r_memwb_p3 <= r_exmem_p2;
      if (bus.stall) begin
        r_idex_p1.valid <= 1'b0;
        if (r_ifid_p0.valid) r_ifid_p0.stall_cnt <= sat_stall(r_ifid_p0.stall_cnt);
      end else begin
        r_idex_p1 <= r_ifid_p0;
        if (bus.flush) begin
          r_ifid_p0.valid <= 1'b0;
        end else begin
          r_ifid_p0 <= '{valid: bus.fetch_valid, id: r_next_id, pc: bus.pc_in,
                         instr: bus.instr_in, fetch_cyc: r_cycle, stall_cnt: '0};
          if (bus.fetch_valid) r_next_id <= r_next_id + ID_W'(1);
        end
      end
    end
  end

  // Stage boundary: MEM/WB retire -> record FIFO
  assign w_push = r_memwb_p3.valid;
  assign w_pop  = !w_empty && bus.rec_ready;
  assign w_rec  = '{id: r_memwb_p3.id, pc: r_memwb_p3.pc, instr: r_memwb_p3.instr,
                    fetch_cyc: r_memwb_p3.fetch_cyc, wb_cyc: r_cycle,
                    stall_cnt: r_memwb_p3.stall_cnt};

  trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_rec),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_drop_cnt <= sat_drop(r_drop_cnt);
      r_overflow <= 1'b1;
    end
  end

  // Storage is not reset, so record fields are masked to zero while the FIFO is empty.
  assign bus.rec_valid     = !w_empty;
  assign bus.rec_id        = w_empty ? '0 : w_head.id;
  assign bus.rec_pc        = w_empty ? '0 : w_head.pc;
  assign bus.rec_instr     = w_empty ? '0 : w_head.instr;
  assign bus.rec_fetch_cyc = w_empty ? '0 : w_head.fetch_cyc;
  assign bus.rec_wb_cyc    = w_empty ? '0 : w_head.wb_cyc;
  assign bus.rec_stall_cnt = w_empty ? '0 : w_head.stall_cnt;
  assign bus.cycle         = r_cycle;
  assign bus.drop_cnt      = r_drop_cnt;
  assign bus.overflow      = r_overflow;

endmodule

// File: tb/tb_pipe_trace_tracker.sv
// Directed scenarios plus randomized traffic against a retire-schedule reference model.
module tb_pipe_trace_tracker;

  logic clk;
  logic rst;

  pipe_trace_tracker_if bus ();

  pipe_trace_tracker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    int unsigned pc;
    int unsigned instr;
    int unsigned fc;
    int unsigned wb;
    int unsigned st;
  } mrec_t;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  // Reference state: one instruction waits in decode, everything past decode retires 3 edges later.
  int unsigned m_cycle;
  int unsigned m_next_id;
  bit          m_held_v;
  mrec_t       m_held;
  mrec_t       m_pend[$];
  mrec_t       m_fifo[$];
  int unsigned m_drop;
  bit          m_ovf;
  int unsigned r_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit fv, input bit st, input bit fl,
                            input bit rdy, input int unsigned pc, input int unsigned ins);
    bit    pop;
    bit    full;
    bit    ret;
    mrec_t rr;
    if (r) begin
      m_cycle = 0; m_next_id = 0; m_held_v = 0; m_drop = 0; m_ovf = 0;
      m_pend.delete(); m_fifo.delete();
      return;
    end
    pop  = (m_fifo.size() != 0) && rdy;
    full = (m_fifo.size() == 8);
    ret  = 0;
    if (m_pend.size() != 0 && m_pend[0].wb == m_cycle) begin
      rr  = m_pend.pop_front();
      ret = 1;
    end
    if (pop) void'(m_fifo.pop_front());
    if (ret) begin
      if (full && !pop) begin
        if (m_drop < 255) m_drop++;
        m_ovf = 1;
      end else begin
        m_fifo.push_back(rr);
      end
    end
    if (st) begin
      if (m_held_v && m_held.st < 15) m_held.st++;
    end else begin
      if (m_held_v) begin
        m_held.wb = m_cycle + 3;
        m_pend.push_back(m_held);
      end
      if (fl) begin
        m_held_v = 0;
      end else begin
        m_held_v = fv;
        m_held   = '{id: m_next_id, pc: pc, instr: ins, fc: m_cycle, wb: 0, st: 0};
        if (fv) m_next_id = (m_next_id + 1) & 32'hFFFF;
      end
    end
    m_cycle++;
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (m_fifo.size() != 0);
    chk("rec_valid", bus.rec_valid, ev);
    chk("rec_id",    bus.rec_id,        ev ? m_fifo[0].id    : 0);
    chk("rec_pc",    bus.rec_pc,        ev ? m_fifo[0].pc    : 0);
    chk("rec_instr", bus.rec_instr,     ev ? m_fifo[0].instr : 0);
    chk("rec_fc",    bus.rec_fetch_cyc, ev ? m_fifo[0].fc    : 0);
    chk("rec_wb",    bus.rec_wb_cyc,    ev ? m_fifo[0].wb    : 0);
    chk("rec_stall", bus.rec_stall_cnt, ev ? m_fifo[0].st    : 0);
    chk("cycle",     bus.cycle,    m_cycle);
    chk("drop_cnt",  bus.drop_cnt, m_drop);
    chk("overflow",  bus.overflow, m_ovf);
  endtask

  task automatic step(input bit r, input bit fv, input bit st, input bit fl, input bit rdy);
    int unsigned ins;
    ins = $urandom & 32'hFFFF;
    rst             = r;
    bus.fetch_valid = fv;
    bus.pc_in       = r_pc[15:0];
    bus.instr_in    = ins[15:0];
    bus.stall       = st;
    bus.flush       = fl;
    bus.rec_ready   = rdy;
    model_edge(r, fv, st, fl, rdy, r_pc & 32'hFFFF, ins);
    @(posedge clk);
    #1;
    if (r) r_pc = 0;
    else if (!st) r_pc = (r_pc + 2) & 32'hFFFF;
    check_outputs();
  endtask

  initial begin
    bit seen;
    r_pc = 0;

    // Steady fetch: first record timing and contents.
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("rst_cycle", bus.cycle, 0);
    chk("rst_valid", bus.rec_valid, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, 1);
      if (!seen && bus.rec_valid) begin
        seen = 1;
        chk("first_cyc",   bus.cycle, 5);
        chk("first_id",    bus.rec_id, 0);
        chk("first_pc",    bus.rec_pc, 0);
        chk("first_fc",    bus.rec_fetch_cyc, 0);
        chk("first_wb",    bus.rec_wb_cyc, 4);
        chk("first_stall", bus.rec_stall_cnt, 0);
      end
    end
    chk("first_seen", seen, 1);

    // Two hazard stalls while id 1 sits in decode.
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);
    chk("stall_id",  bus.rec_id, 1);
    chk("stall_fc",  bus.rec_fetch_cyc, 1);
    chk("stall_wb",  bus.rec_wb_cyc, 7);
    chk("stall_cnt", bus.rec_stall_cnt, 2);

    // Flush at the edge where cycle is 3.
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);
    chk("flush_gap", bus.rec_valid, 0);
    step(0, 1, 0, 0, 1);
    chk("flush_id", bus.rec_id, 3);
    chk("flush_fc", bus.rec_fetch_cyc, 4);
    chk("flush_wb", bus.rec_wb_cyc, 8);

    // Overflow: 12 retires into an unread 8-entry FIFO, then drain.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    chk("ovf_drop", bus.drop_cnt, 4);
    chk("ovf_flag", bus.overflow, 1);
    for (int k = 0; k < 8; k++) begin
      chk("ovf_pop_id", bus.rec_id, k);
      step(0, 0, 0, 0, 1);
    end
    chk("ovf_empty", bus.rec_valid, 0);

    // Reset mid-operation with records queued and instructions in flight.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
    chk("pre_rst_valid", bus.rec_valid, 1);
    step(1, 1, 0, 0, 0);
    chk("mid_rst_valid", bus.rec_valid, 0);
    chk("mid_rst_cycle", bus.cycle, 0);
    chk("mid_rst_ovf",   bus.overflow, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1);
    chk("post_rst_id", bus.rec_id, 0);
    chk("post_rst_fc", bus.rec_fetch_cyc, 0);

    // Randomized traffic, including combined stall+flush and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 9) < 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
